// File: rtl/ex2mem_skid_reg.sv
// rtl/ex2mem_skid_reg.sv - EX->MEM pipeline register with 2-entry skid buffer
//
// Purpose:
//   Registers the EX-stage result for the MEM stage behind a valid/ready
//   handshake. A main register (M) drives the outputs and a skid register (S)
//   catches one entry when MEM stalls. Because of S, in_ready depends only on
//   state and never combinationally on out_ready. A synchronous flush kills
//   both entries. Control enables are forced to 0 whenever the output is a
//   bubble.
//
// Optional feature (macro EX2MEM_STALL_CNT_EN):
//   Adds parameter CNT_W and output stall_cnt. The counter counts cycles with
//   out_valid=1 and out_ready=0, saturates at all-ones and is cleared only by
//   reset.
//
// Ports:
//   clk          in   rising-edge clock
//   rst          in   asynchronous active-low reset
//   flush        in   synchronous kill of held and incoming entries
//   in_valid     in   EX presents an instruction
//   in_ready     out  stage can accept (skid register empty)
//   in_wb_en, in_mem_r_en, in_mem_w_en, in_zero, in_branch  in  EX control/flags
//   in_alu_res   in   ALU result / memory address      [DATA_W]
//   in_st_val    in   store data                       [DATA_W]
//   in_dest      in   writeback register index         [REG_AW]
//   out_valid    out  MEM-side entry valid
//   out_ready    in   MEM consumes the entry this cycle
//   out_wb_en, out_mem_r_en, out_mem_w_en, out_zero, out_branch  out
//   out_alu_res  out  [DATA_W]
//   out_st_val   out  [DATA_W]
//   out_dest     out  [REG_AW]
//   stall_cnt    out  [CNT_W] stall counter (optional feature only)

module ex2mem_skid_reg #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
`ifdef EX2MEM_STALL_CNT_EN
  ,
  parameter int CNT_W  = 16
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_wb_en,
  input  logic              in_mem_r_en,
  input  logic              in_mem_w_en,
  input  logic              in_zero,
  input  logic              in_branch,
  input  logic [DATA_W-1:0] in_alu_res,
  input  logic [DATA_W-1:0] in_st_val,
  input  logic [REG_AW-1:0] in_dest,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_wb_en,
  output logic              out_mem_r_en,
  output logic              out_mem_w_en,
  output logic              out_zero,
  output logic              out_branch,
  output logic [DATA_W-1:0] out_alu_res,
  output logic [DATA_W-1:0] out_st_val,
  output logic [REG_AW-1:0] out_dest
`ifdef EX2MEM_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt
`endif
);

  typedef struct packed {
    logic              wb_en;
    logic              mem_r_en;
    logic              mem_w_en;
    logic              zero;
    logic              branch;
    logic [DATA_W-1:0] alu_res;
    logic [DATA_W-1:0] st_val;
    logic [REG_AW-1:0] dest;
  } payload_t;

  // Turns an entry into a bubble-safe one: enables off, data left alone.
  function automatic payload_t kill_ctrl(input payload_t p);
    payload_t q;
    q          = p;
    q.wb_en    = 1'b0;
    q.mem_r_en = 1'b0;
    q.mem_w_en = 1'b0;
    q.branch   = 1'b0;
    return q;
  endfunction

  logic     r_m_valid;
  payload_t r_m;
  logic     r_s_valid;
  payload_t r_s;

  payload_t w_in;
  logic     w_accept;
  logic     w_drain;
  logic     w_m_free;

  assign w_in.wb_en    = in_wb_en;
  assign w_in.mem_r_en = in_mem_r_en;
  assign w_in.mem_w_en = in_mem_w_en;
  assign w_in.zero     = in_zero;
  assign w_in.branch   = in_branch;
  assign w_in.alu_res  = in_alu_res;
  assign w_in.st_val   = in_st_val;
  assign w_in.dest     = in_dest;

  // in_ready comes from S only, which cuts the out_ready->in_ready path.
  assign in_ready = ~r_s_valid;
  assign w_accept = in_valid & in_ready;
  assign w_drain  = r_m_valid & out_ready;
  // M can take a new entry at this edge if it is empty or being consumed.
  assign w_m_free = ~r_m_valid | w_drain;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_m_valid <= 1'b0;
      r_s_valid <= 1'b0;
      r_m       <= '0;
      r_s       <= '0;
    end else if (flush) begin
      r_m_valid <= 1'b0;
      r_s_valid <= 1'b0;
      r_m       <= kill_ctrl(r_m);
    end else if (w_m_free) begin
      if (r_s_valid) begin
        // Oldest entry lives in S; promote it to keep FIFO order.
        r_m       <= r_s;
        r_m_valid <= 1'b1;
        r_s_valid <= w_accept;
        if (w_accept) begin
          r_s <= w_in;
        end
      end else if (w_accept) begin
        r_m       <= w_in;
        r_m_valid <= 1'b1;
      end else begin
        r_m_valid <= 1'b0;
        r_m       <= kill_ctrl(r_m);
      end
    end else if (w_accept) begin
      // M stalled: park the incoming entry in S.
      r_s       <= w_in;
      r_s_valid <= 1'b1;
    end
  end

  assign out_valid    = r_m_valid;
  assign out_wb_en    = r_m.wb_en;
  assign out_mem_r_en = r_m.mem_r_en;
  assign out_mem_w_en = r_m.mem_w_en;
  assign out_zero     = r_m.zero;
  assign out_branch   = r_m.branch;
  assign out_alu_res  = r_m.alu_res;
  assign out_st_val   = r_m.st_val;
  assign out_dest     = r_m.dest;

`ifdef EX2MEM_STALL_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic             w_stall;

  assign w_stall = r_m_valid & ~out_ready;

  // Flush deliberately does not clear the counter; only reset does.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cnt <= '0;
    end else if (w_stall && !(&r_stall_cnt)) begin
      r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule
